// File: rtl/data_gen.sv
// Test-pattern source for the seven-segment display path: a decimal count that
// advances once per time slot and wraps at DATA_MAX, plus constant display controls.
module data_gen #(
    parameter logic [22:0] TIME_MAX = 23'd4_999_999,
    parameter logic [19:0] DATA_MAX = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en
);

    logic [22:0] cnt_slot;
    logic        slot_end;

    assign slot_end = (cnt_slot == TIME_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_slot <= 23'd0;
        end else if (slot_end) begin
            cnt_slot <= 23'd0;
        end else begin
            cnt_slot <= cnt_slot + 23'd1;
        end
    end

    // >= rather than == so an out-of-range value can never keep counting upward
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data <= 20'd0;
        end else if (slot_end) begin
            if (data >= DATA_MAX) begin
                data <= 20'd0;
            end else begin
                data <= data + 20'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            point  <= 6'b000000;
            sign   <= 1'b0;
            seg_en <= 1'b0;
        end else begin
            point  <= 6'b000000;
            sign   <= 1'b0;
            seg_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_gen.sv
// Bench for data_gen: two instances (10-cycle slots wrapping at 9, and 1-cycle
// slots wrapping at 3) compared each cycle against an edge-count arithmetic model.
module tb_data_gen;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [19:0] data_a, data_b;
    logic [5:0]  point_a, point_b;
    logic        sign_a, sign_b;
    logic        seg_en_a, seg_en_b;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int n      = 0;   // rising edges seen with reset released

    localparam int SLOT_A = 10;
    localparam int WRAP_A = 10;
    localparam int SLOT_B = 1;
    localparam int WRAP_B = 4;

    data_gen #(.TIME_MAX(23'd9), .DATA_MAX(20'd9)) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data_a),
        .point     (point_a),
        .sign      (sign_a),
        .seg_en    (seg_en_a)
    );

    data_gen #(.TIME_MAX(23'd0), .DATA_MAX(20'd3)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data_b),
        .point     (point_b),
        .sign      (sign_b),
        .seg_en    (seg_en_b)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        int exp_a, exp_b, exp_en;
        exp_a  = (n / SLOT_A) % WRAP_A;
        exp_b  = (n / SLOT_B) % WRAP_B;
        exp_en = (n >= 1) ? 1 : 0;
        check("data_a",   32'(data_a),   32'(exp_a));
        check("data_b",   32'(data_b),   32'(exp_b));
        check("seg_en_a", 32'(seg_en_a), 32'(exp_en));
        check("seg_en_b", 32'(seg_en_b), 32'(exp_en));
        check("point_a",  32'(point_a),  32'd0);
        check("point_b",  32'(point_b),  32'd0);
        check("sign_a",   32'(sign_a),   32'd0);
        check("sign_b",   32'(sign_b),   32'd0);
        check("range_a",  32'(data_a <= 20'd9), 32'd1);
    endtask

    task automatic step();
        @(posedge sys_clk);
        if (sys_rst_n) n++;
        @(negedge sys_clk);
        check_all();
    endtask

    initial begin
        int run_len;
        int waited;
        sys_rst_n = 1'b0;
        #20;
        check_all();
        repeat (2) step();

        for (int round = 0; round < 4; round++) begin
            @(negedge sys_clk);
            sys_rst_n = 1'b1;
            run_len = int'($urandom_range(60, 140));
            for (int i = 0; i < run_len; i++) step();

            waited = 0;
            while (data_a != 20'd5 && waited < 200) begin
                step();
                waited++;
            end
            check("wait_for_5", 32'(data_a), 32'd5);

            // assert reset between edges; outputs must clear without a clock edge
            #($urandom_range(1, 8));
            sys_rst_n = 1'b0;
            n = 0;
            #1;
            check_all();
            repeat ($urandom_range(1, 4)) step();
        end

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (25) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
